// File: rtl/spi_cmd_sequencer.sv
// Command-to-SPI sequencer: one address byte plus RESP_BYTES dummy bytes per command,
// with the response bytes buffered in a FIFO and returned with a last-byte marker.
module spi_cmd_sequencer #(
  parameter int         CMD_W        = 3,
  parameter logic [7:0] ADDR_BASE    = 8'h00,
  parameter int         RESP_BYTES   = 2,
  parameter int         NUM_CS       = 1,
  parameter int         FIFO_DEPTH   = 8,
  parameter int         TIMEOUT_CLKS = 1024,
  localparam int        CNT_W        = $clog2(RESP_BYTES + 2),
  localparam int        CH_W         = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int        LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd,
  input  logic [CH_W-1:0]  cmd_chan,
  output logic [CH_W-1:0]  spi_chan_sel,
  output logic [CNT_W-1:0] spi_tx_count,
  output logic [7:0]       spi_tx_byte,
  output logic             spi_tx_dv,
  input  logic             spi_tx_ready,
  input  logic             spi_rx_dv,
  input  logic [7:0]       spi_rx_byte,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [7:0]       resp_byte,
  output logic             resp_last,
  output logic [LVL_W-1:0] fifo_level,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMR_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  localparam logic [LVL_W-1:0] LVL_ACCEPT_MAX = LVL_W'(FIFO_DEPTH - RESP_BYTES);
  localparam logic [CNT_W-1:0] IDX_DONE       = CNT_W'(RESP_BYTES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST       = TMR_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_out_en;
  logic [7:0]         r_addr;
  logic [CH_W-1:0]    r_chan;
  logic [CNT_W-1:0]   r_tx_idx;
  logic [TMR_W-1:0]   r_timer;
  logic               r_timeout_err;
  logic [8:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;

  logic               w_cmd_ready;
  logic               w_accept;
  logic               w_tx_dv;
  logic               w_push;
  logic               w_push_last;
  logic               w_pop;
  logic               w_timeout;
  logic [LVL_W-1:0]   w_level;
  logic [7:0]         w_addr;
  logic [CH_W-1:0]    w_chan;
  logic [8:0]         w_head;

  assign w_level = LVL_W'(r_wr_ptr - r_rd_ptr);
  assign w_addr  = ADDR_BASE + 8'(cmd);
  assign w_chan  = (int'(cmd_chan) >= NUM_CS) ? '0 : cmd_chan;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // r_out_en keeps cmd_ready low while reset is asserted, even though IDLE with an empty FIFO would allow it.
  assign w_cmd_ready = r_out_en && (r_state == S_IDLE) && (w_level <= LVL_ACCEPT_MAX);
  assign w_pop       = resp_valid && resp_ready;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_tx_dv     = 1'b0;
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid && w_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (spi_tx_ready) begin
          w_tx_dv     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (spi_rx_dv) begin
          // r_tx_idx already counts the byte in flight; index 0 is the address echo.
          w_push      = (r_tx_idx > CNT_W'(1));
          w_push_last = (r_tx_idx == IDX_DONE);
          w_state_nxt = w_push_last ? S_IDLE : S_SEND;
        end else if (r_timer == TMR_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_out_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_out_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr        <= '0;
      r_chan        <= '0;
      r_tx_idx      <= '0;
      r_timer       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr   <= w_addr;
        r_chan   <= w_chan;
        r_tx_idx <= '0;
      end
      if (w_tx_dv) begin
        r_tx_idx <= r_tx_idx + CNT_W'(1);
        r_timer  <= '0;
      end else if (r_state == S_WAIT) begin
        r_timer <= spi_rx_dv ? '0 : r_timer + TMR_W'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (err_clr) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  // NOTE: the FIFO storage is reset as well, because the head entry drives outputs that must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= {w_push_last, spi_rx_byte};
        r_wr_ptr                <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  assign cmd_ready    = w_cmd_ready;
  assign spi_chan_sel = r_chan;
  assign spi_tx_count = IDX_DONE;
  assign spi_tx_byte  = (r_tx_idx == '0) ? r_addr : 8'h00;
  assign spi_tx_dv    = w_tx_dv;
  assign resp_valid   = (r_wr_ptr != r_rd_ptr);
  assign resp_byte    = w_head[7:0];
  assign resp_last    = w_head[8];
  assign fifo_level   = w_level;
  assign busy         = (r_state != S_IDLE);
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Randomised bench for spi_cmd_sequencer: a behavioural SPI target and a command-level
// queue model predict every byte sent and every response byte delivered.
module tb_spi_cmd_sequencer;

  localparam int         P_CMD_W  = 3;
  localparam logic [7:0] P_BASE   = 8'hFE;
  localparam int         P_RESP   = 2;
  localparam int         P_NUM_CS = 3;
  localparam int         P_DEPTH  = 4;
  localparam int         P_TMO    = 16;
  localparam int         CNT_W    = $clog2(P_RESP + 2);
  localparam int         CH_W     = (P_NUM_CS > 1) ? $clog2(P_NUM_CS) : 1;
  localparam int         LVL_W    = $clog2(P_DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [P_CMD_W-1:0] cmd = '0;
  logic [CH_W-1:0]    cmd_chan = '0;
  logic [CH_W-1:0]    spi_chan_sel;
  logic [CNT_W-1:0]   spi_tx_count;
  logic [7:0]         spi_tx_byte;
  logic               spi_tx_dv;
  logic               spi_tx_ready;
  logic               spi_rx_dv;
  logic [7:0]         spi_rx_byte;
  logic               resp_valid;
  logic               resp_ready;
  logic [7:0]         resp_byte;
  logic               resp_last;
  logic [LVL_W-1:0]   fifo_level;
  logic               busy;
  logic               timeout_err;
  logic               err_clr = 1'b0;

  spi_cmd_sequencer #(
    .CMD_W(P_CMD_W), .ADDR_BASE(P_BASE), .RESP_BYTES(P_RESP),
    .NUM_CS(P_NUM_CS), .FIFO_DEPTH(P_DEPTH), .TIMEOUT_CLKS(P_TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_chan(cmd_chan), .spi_chan_sel(spi_chan_sel),
    .spi_tx_count(spi_tx_count), .spi_tx_byte(spi_tx_byte), .spi_tx_dv(spi_tx_dv),
    .spi_tx_ready(spi_tx_ready), .spi_rx_dv(spi_rx_dv), .spi_rx_byte(spi_rx_byte),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_byte(resp_byte),
    .resp_last(resp_last), .fifo_level(fifo_level), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; int idx; int chan; } tx_exp_t;
  typedef struct { logic [7:0] b; logic last; } resp_t;

  tx_exp_t exp_tx_q[$];
  resp_t   exp_resp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cons_mode = 0;
  int pop_budget = 0;
  int max_level = 0;
  bit stream_mon = 0;
  bit tx_rand = 0;
  bit outstanding = 0;
  bit withheld = 0;
  bit inject_rx = 0;
  int withheld_cyc = 0;
  int withhold_idx = -1;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_addr(input int c);
    return 8'((int'(P_BASE) + c) % 256);
  endfunction

  function automatic int exp_chan(input int ch);
    return (ch >= P_NUM_CS) ? 0 : ch;
  endfunction

  // SPI target: answers each transmitted byte after a random delay, optionally withholding one index.
  initial begin : spi_target
    bit         pend;
    int         dly;
    int         pidx;
    logic [7:0] pb;
    tx_exp_t    e;
    pend = 0; dly = 0; pidx = 0; pb = '0;
    spi_rx_dv = 1'b0; spi_rx_byte = '0; spi_tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      spi_rx_dv = 1'b0;
      if (!rst_n) begin
        pend = 0;
        outstanding = 0;
      end else if (pend) begin
        if (dly == 0) begin
          spi_rx_dv   = 1'b1;
          spi_rx_byte = pb;
          pend        = 0;
          outstanding = 0;
          if (pidx > 0) exp_resp_q.push_back('{b: pb, last: (pidx == P_RESP)});
        end else begin
          dly--;
        end
      end else if (inject_rx) begin
        spi_rx_dv   = 1'b1;
        spi_rx_byte = 8'($urandom);
        inject_rx   = 0;
      end
      spi_tx_ready = tx_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (rst_n && spi_tx_dv) begin
        check("tx_one_outstanding", 32'(outstanding), 0);
        if (exp_tx_q.size() == 0) begin
          check("tx_unexpected", 1, 0);
        end else begin
          e = exp_tx_q.pop_front();
          check("tx_byte", spi_tx_byte, e.b);
          check("tx_chan", spi_chan_sel, e.chan);
          outstanding = 1;
          if (e.idx == withhold_idx) begin
            withheld     = 1;
            withheld_cyc = cyc;
          end else begin
            pend = 1;
            dly  = $urandom_range(0, 3);
            pb   = 8'($urandom);
            pidx = e.idx;
          end
        end
      end
    end
  end

  // Response consumer: compares every popped byte against the model in order.
  initial begin : consumer
    resp_t e;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (cons_mode)
        1:       resp_ready = 1'b1;
        2:       resp_ready = ($urandom_range(0, 1) == 1);
        default: resp_ready = (pop_budget > 0);
      endcase
      if (stream_mon && int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (rst_n && resp_valid && resp_ready) begin
        if (exp_resp_q.size() == 0) begin
          check("resp_unexpected", 1, 0);
        end else begin
          e = exp_resp_q.pop_front();
          check("resp_byte", resp_byte, e.b);
          check("resp_last", 32'(resp_last), 32'(e.last));
        end
        if (pop_budget > 0) pop_budget--;
      end
    end
  end

  task automatic send_cmd(input int c, input int ch, input int budget, output bit ok);
    ok        = 0;
    cmd       = c[P_CMD_W-1:0];
    cmd_chan  = ch[CH_W-1:0];
    cmd_valid = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      if (cmd_ready) begin
        ok = 1;
        for (int k = 0; k <= P_RESP; k++)
          exp_tx_q.push_back('{b: (k == 0) ? exp_addr(c) : 8'h00, idx: k, chan: exp_chan(ch)});
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (!busy && exp_tx_q.size() == 0 && !outstanding) done = 1;
      else @(negedge clk);
    end
    check(tag, 32'(done), 1);
  endtask

  task automatic drain(input string tag);
    bit done = 0;
    cons_mode = 1;
    for (int i = 0; i < 400 && !done; i++) begin
      if (exp_resp_q.size() == 0 && !resp_valid && !busy && exp_tx_q.size() == 0) done = 1;
      else @(negedge clk);
    end
    check(tag, 32'(done), 1);
  endtask

  task automatic check_reset_outs(input string p);
    check({p, "_busy"}, 32'(busy), 0);
    check({p, "_cmd_ready"}, 32'(cmd_ready), 0);
    check({p, "_tx_dv"}, 32'(spi_tx_dv), 0);
    check({p, "_tx_byte"}, spi_tx_byte, 0);
    check({p, "_chan_sel"}, spi_chan_sel, 0);
    check({p, "_resp_valid"}, 32'(resp_valid), 0);
    check({p, "_resp_byte"}, resp_byte, 0);
    check({p, "_resp_last"}, 32'(resp_last), 0);
    check({p, "_level"}, fifo_level, 0);
    check({p, "_timeout_err"}, 32'(timeout_err), 0);
    check({p, "_tx_count"}, spi_tx_count, P_RESP + 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit ok;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_cmd_ready", 32'(cmd_ready), 1);

    // Single command on channel 1.
    send_cmd(3, 1, 10, ok);
    check("single_accept", 32'(ok), 1);
    check("single_lat_dv", 32'(spi_tx_dv), 1);
    check("single_addr", spi_tx_byte, exp_addr(3));
    check("single_chan", spi_chan_sel, 1);
    check("single_busy", 32'(busy), 1);
    check("single_cmd_ready_low", 32'(cmd_ready), 0);
    wait_idle("single_done");
    check("single_level", fifo_level, 2);
    check("single_model_cnt", exp_resp_q.size(), 2);
    if (exp_resp_q.size() > 0) begin
      check("single_head_byte", resp_byte, exp_resp_q[0].b);
      check("single_head_last", 32'(resp_last), 0);
    end

    // Address wrap and out-of-range channel mapping.
    send_cmd(5, 3, 10, ok);
    check("wrap_accept", 32'(ok), 1);
    check("wrap_addr", spi_tx_byte, 8'h03);
    check("wrap_chan", spi_chan_sel, 0);
    wait_idle("wrap_done");
    drain("drain_1");
    cons_mode = 0;

    // Back-pressure: a third command must wait for FIFO space.
    send_cmd(1, 2, 10, ok);
    check("bp_first_accept", 32'(ok), 1);
    wait_idle("bp_first_done");
    send_cmd(2, 0, 10, ok);
    check("bp_second_accept", 32'(ok), 1);
    wait_idle("bp_second_done");
    check("bp_level_full", fifo_level, 4);
    send_cmd(4, 1, 20, ok);
    check("bp_third_blocked", 32'(ok), 0);
    check("bp_cmd_ready_low", 32'(cmd_ready), 0);
    pop_budget = 2;
    for (int i = 0; i < 50 && pop_budget > 0; i++) @(negedge clk);
    @(negedge clk);
    check("bp_level_after_pop", fifo_level, 2);
    check("bp_cmd_ready_high", 32'(cmd_ready), 1);
    send_cmd(4, 1, 10, ok);
    check("bp_third_accept", 32'(ok), 1);
    wait_idle("bp_third_done");
    drain("drain_2");
    cons_mode = 0;

    // Timeout on the second response byte.
    withhold_idx = 2;
    send_cmd(6, 2, 10, ok);
    check("tmo_accept", 32'(ok), 1);
    for (int i = 0; i < 100 && !withheld; i++) @(negedge clk);
    check("tmo_withheld_seen", 32'(withheld), 1);
    while (cyc < withheld_cyc + P_TMO) @(negedge clk);
    check("tmo_err_early", 32'(timeout_err), 0);
    check("tmo_busy_early", 32'(busy), 1);
    @(negedge clk);
    check("tmo_err_set", 32'(timeout_err), 1);
    check("tmo_idle", 32'(busy), 0);
    check("tmo_level", fifo_level, 1);
    check("tmo_head_last", 32'(resp_last), 0);
    if (exp_resp_q.size() > 0) check("tmo_head_byte", resp_byte, exp_resp_q[0].b);
    exp_tx_q.delete();
    withhold_idx = -1;
    withheld     = 0;
    outstanding  = 0;
    inject_rx    = 1;
    repeat (4) @(negedge clk);
    check("tmo_spurious_level", fifo_level, 1);
    check("tmo_spurious_busy", 32'(busy), 0);
    send_cmd(7, 0, 10, ok);
    check("tmo_err_no_block", 32'(ok), 1);
    wait_idle("tmo_next_done");
    check("tmo_err_sticky", 32'(timeout_err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("tmo_err_cleared", 32'(timeout_err), 0);
    drain("drain_3");

    // Streaming with resp_ready held high.
    max_level  = 0;
    stream_mon = 1;
    for (int n = 0; n < 8; n++) begin
      send_cmd($urandom_range(0, 7), $urandom_range(0, 2), 100, ok);
      check("stream_accept", 32'(ok), 1);
    end
    drain("drain_stream");
    stream_mon = 0;
    check("stream_max_level", max_level, 1);

    // Asynchronous reset while waiting on the second response byte.
    cons_mode    = 0;
    withhold_idx = 2;
    send_cmd(2, 1, 10, ok);
    check("rst_accept", 32'(ok), 1);
    for (int i = 0; i < 100 && !withheld; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("rst_pre_level", fifo_level, 1);
    check("rst_pre_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("rst_mid");
    exp_tx_q.delete();
    exp_resp_q.delete();
    withhold_idx = -1;
    withheld     = 0;
    outstanding  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_cmd(4, 2, 10, ok);
    check("rst_fresh_accept", 32'(ok), 1);
    drain("drain_after_rst");

    // Random commands, channels, tx_ready stalls and consumer back-pressure.
    tx_rand   = 1;
    cons_mode = 2;
    for (int n = 0; n < 25; n++) begin
      send_cmd($urandom_range(0, 7), $urandom_range(0, 3), 200, ok);
      check("rand_accept", 32'(ok), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain("drain_rand");
    tx_rand = 0;

    check("end_tx_q_empty", exp_tx_q.size(), 0);
    check("end_resp_q_empty", exp_resp_q.size(), 0);
    check("end_resp_valid", 32'(resp_valid), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
